fp_mul: RTL and testbench

IEEE-754 single-precision multiplier, the multiplicative counterpart of the team's iterative FP divider, sharing the same start/done/flags interface so both can sit behind one FPU opcode decoder. The mantissa product is formed by a serial shift-add multiplier, one bit per cycle. Latency is fixed regardless of operand values. Round-to-nearest-even; denormals are flushed to zero.

---
 rtl/fp_mul_pkg.sv | 33 +++
 rtl/fp_mul_mul_serial.sv | 68 ++++++
 rtl/fp_mul.sv | 210 +++++++++++++++++++++
 tb/tb_fp_mul.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared definitions for the single-precision multiplier: IEEE-754 field
// widths and constants, operand classes and the control FSM encoding.
package fp_mul_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 1;

  localparam int          FP_BIAS    = 127;
  localparam int          FP_EXP_MAX = 255;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

  // One edge to capture, MANT_W multiply steps, then NORM and PACK.
  localparam int FP_LATENCY = MANT_W + 2;

  // Control FSM. DONE behaves exactly like IDLE but marks a valid result.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_NORM = 3'd2,
    ST_PACK = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Operand-pair class, decided once at capture time.
  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } cls_t;

endpackage

// File: rtl/fp_mul_mul_serial.sv
// Unsigned DATA_W x DATA_W shift-add multiplier, one multiplier bit per cycle,
// LSB first. The multiplier sits in the low half of the accumulator and is
// shifted out as partial sums are shifted in from the top.
// Handshake: a start pulse (re)loads the operands at any time, aborting any
// step sequence in progress; done is low for exactly DATA_W cycles after the
// loading edge, and product is valid and stable whenever done is high.
module mul_serial #(
  parameter int DATA_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [DATA_W:0]     sum;

  // Next-state: load on start, otherwise one add-and-shift step while busy.
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    sum     = {1'b0, acc_q[2*DATA_W-1:DATA_W]} +
              (acc_q[0] ? {1'b0, mcand_q} : '0);
    if (start) begin
      acc_d   = {{DATA_W{1'b0}}, b};
      mcand_d = a;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      acc_d = {sum, acc_q[DATA_W-1:1]};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign done    = ~busy_q;
  assign product = acc_q;

endmodule

// File: rtl/fp_mul.sv
// IEEE-754 single-precision multiplier with a fixed-latency start/done
// interface. Unpack and special-case detection happen on the start edge,
// the mantissa product comes from the serial multiplier, then one cycle each
// for normalize and round/pack. Denormal inputs are flushed to zero.
// Handshake: start is a one-cycle pulse sampled on an edge (E0); done drops
// after E0 and rises on E0+LATENCY with res/flags valid; they then hold until
// the next start. A start while busy aborts and restarts the operation.
module fp_mul
  import fp_mul_pkg::*;
#(
  parameter int LATENCY = FP_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        done,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        overflow,
  output logic        underflow,
  output logic        exception,
  output logic [31:0] res,
  output state_t      dbg_state
);

  localparam logic [4:0]        MUL_LAST  = 5'(LATENCY - 3);
  localparam logic signed [9:0] EXP_MAX_S = 10'(FP_EXP_MAX);

  // Operand unpack (combinational, only used on the start edge).
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic [MANT_W-1:0] ma, mb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic signed [9:0] exp_start;
  cls_t              cls_start;

  assign ea = op_a[30:23];
  assign eb = op_b[30:23];
  assign fa = op_a[22:0];
  assign fb = op_b[22:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);
  assign ma = a_zero ? '0 : {1'b1, fa};
  assign mb = b_zero ? '0 : {1'b1, fb};
  assign exp_start = 10'(ea) + 10'(eb) - 10'(FP_BIAS);

  // Operand-pair class, in priority order: NaN beats inf beats zero.
  always_comb begin
    cls_start = CLS_NORMAL;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      cls_start = CLS_NAN;
    end else if (a_inf || b_inf) begin
      cls_start = CLS_INF;
    end else if (a_zero || b_zero) begin
      cls_start = CLS_ZERO;
    end
  end

  logic                    mul_done;
  logic [2*MANT_W-1:0]     product;

  mul_serial #(.DATA_W(MANT_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (ma),
    .b       (mb),
    .done    (mul_done),
    .product (product)
  );

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic signed [9:0] exp_q, exp_d;
  cls_t              cls_q, cls_d;
  logic [FRAC_W-1:0] mant_q, mant_d;
  logic              guard_q, guard_d;
  logic              sticky_q, sticky_d;
  logic [31:0]       res_q, res_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              exc_q, exc_d;

  logic              round_inc;
  logic [MANT_W-1:0] mant_r;
  logic signed [9:0] exp_r;
  logic [FRAC_W-1:0] frac_r;

  // FSM next state plus the normalize and round/pack datapath.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    cls_d     = cls_q;
    mant_d    = mant_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    exc_d     = exc_q;
    round_inc = guard_q & (sticky_q | mant_q[0]);
    mant_r    = {1'b0, mant_q} + {{(MANT_W-1){1'b0}}, round_inc};
    exp_r     = exp_q + $signed({9'b0, mant_r[MANT_W-1]});
    frac_r    = mant_r[MANT_W-1] ? '0 : mant_r[FRAC_W-1:0];

    case (state_q)
      ST_MUL: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == MUL_LAST) begin
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        if (mul_done) begin
          if (product[47]) begin
            mant_d   = product[46:24];
            guard_d  = product[23];
            sticky_d = |product[22:0];
            exp_d    = exp_q + 10'sd1;
          end else begin
            mant_d   = product[45:23];
            guard_d  = product[22];
            sticky_d = |product[21:0];
          end
          state_d = ST_PACK;
        end
      end
      ST_PACK: begin
        state_d = ST_DONE;
        case (cls_q)
          CLS_NAN: begin
            res_d = FP_QNAN;
            exc_d = 1'b1;
          end
          CLS_INF:  res_d = {sign_q, 8'hFF, 23'b0};
          CLS_ZERO: res_d = {sign_q, 31'b0};
          default: begin
            if (exp_r >= EXP_MAX_S) begin
              res_d = {sign_q, 8'hFF, 23'b0};
              ovf_d = 1'b1;
            end else if (exp_r <= 10'sd0) begin
              res_d = {sign_q, 31'b0};
              unf_d = 1'b1;
            end else begin
              res_d = {sign_q, exp_r[7:0], frac_r};
            end
          end
        endcase
      end
      default: ;
    endcase

    if (start) begin
      state_d = ST_MUL;
      cnt_d   = '0;
      sign_d  = op_a[31] ^ op_b[31];
      exp_d   = exp_start;
      cls_d   = cls_start;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      exc_d   = 1'b0;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      cls_q    <= CLS_NORMAL;
      mant_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      cls_q    <= cls_d;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      exc_q    <= exc_d;
    end
  end

  assign done      = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign res       = res_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign exception = exc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fp_mul.sv
// Directed bench for fp_mul: reset values, latency, rounding, overflow,
// underflow, special operands, abort-by-restart and asynchronous reset.
module tb_fp_mul;
  import fp_mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        done, overflow, underflow, exception;
  logic [31:0] res;
  state_t      dbg_state;

  int checks = 0;
  int passed = 0;
  int lat;
  int bad;

  fp_mul dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .done      (done),
    .op_a      (op_a),
    .op_b      (op_b),
    .overflow  (overflow),
    .underflow (underflow),
    .exception (exception),
    .res       (res),
    .dbg_state (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive one start pulse, then count edges until done rises (bounded).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int n);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("done_low_after_start", 32'(done), 32'd0);
    n = 1;
    @(posedge clk);
    #1;
    while (!done && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic op_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic [2:0] exp_flags);
    int n;
    run_op(a, b, n);
    check({tag, "_latency"}, 32'(n), 32'd26);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_flags"}, {29'b0, overflow, underflow, exception}, {29'b0, exp_flags});
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    #1;
    check("reset_done", 32'(done), 32'd1);
    check("reset_res", res, 32'h0);
    check("reset_flags", {29'b0, overflow, underflow, exception}, 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Flags order below: {overflow, underflow, exception}.
    op_check("mul_1p5_x_2", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000);
    check("state_done", 32'(dbg_state), 32'(ST_DONE));
    op_check("neg3_x_half", 32'hC040_0000, 32'h3F00_0000, 32'hBFC0_0000, 3'b000);
    op_check("sticky_only", 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 3'b000);
    op_check("tie_to_even", 32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002, 3'b000);
    op_check("overflow", 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 3'b100);
    op_check("underflow", 32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 3'b010);
    op_check("inf_x_zero", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b001);
    op_check("nan_in", 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b001);
    op_check("neg_inf_x_2", 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 3'b000);
    op_check("zero_x_neg", 32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 3'b000);

    // Result must hold while idle.
    repeat (5) @(posedge clk);
    #1;
    check("hold_res", res, 32'h8000_0000);
    check("hold_done", 32'(done), 32'd1);

    // Restart while busy: 2*2 aborted on its 10th edge by 3*3.
    @(negedge clk);
    op_a  = 32'h4000_0000;
    op_b  = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort_busy_before_restart", 32'(done), 32'd0);
    run_op(32'h4040_0000, 32'h4040_0000, lat);
    check("abort_latency", 32'(lat), 32'd26);
    check("abort_res", res, 32'h4110_0000);
    bad = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (!done || res !== 32'h4110_0000) bad++;
    end
    check("abort_single_done", 32'(bad), 32'd0);

    // Asynchronous reset on the 12th edge of an operation.
    @(negedge clk);
    op_a  = 32'h4000_0000;
    op_b  = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_done", 32'(done), 32'd1);
    check("arst_res", res, 32'h0);
    check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (!done || res !== 32'h0 || overflow || underflow || exception) bad++;
    end
    check("arst_quiet_after_release", 32'(bad), 32'd0);

    // Normal operation resumes after reset.
    op_check("after_reset", 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 3'b000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
